// File: rtl/demux_pkg.sv
// demux_pkg
//   Shared definitions for the registered 1-to-4 demultiplexer.
//   NUM_CH / SEL_W size the channel fan-out and the select field,
//   CH_A..CH_D name the channel indices, and sel_decode turns a
//   select value into a one-hot channel mask.
package demux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    localparam logic [SEL_W-1:0] CH_A = 2'd0;
    localparam logic [SEL_W-1:0] CH_B = 2'd1;
    localparam logic [SEL_W-1:0] CH_C = 2'd2;
    localparam logic [SEL_W-1:0] CH_D = 2'd3;

    // One-hot decode of a channel select.
    function automatic logic [NUM_CH-1:0] sel_decode(input logic [SEL_W-1:0] sel);
        logic [NUM_CH-1:0] onehot;
        onehot      = '0;
        onehot[sel] = 1'b1;
        return onehot;
    endfunction

endpackage

// File: rtl/demux_chan_slot.sv
// demux_chan_slot
//   One output slot of the demultiplexer: a single-word holding
//   register with its valid flag and a saturating transfer counter.
//
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : write d into the slot this edge (slot becomes valid)
//   pop        : consumer handshake this edge (valid && ready)
//   d          : word to load
//   o_valid    : slot holds a word
//   o_data     : held word; keeps the last word after it is popped
//   o_cnt      : completed output handshakes, saturating at all-ones
module demux_chan_slot #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             pop,
    input  logic [WIDTH-1:0] d,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [CNT_W-1:0] o_cnt
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_cnt   <= '0;
        end else begin
            // A load on the same edge as a pop reloads the slot, so
            // load takes priority over the clear.
            if (load) begin
                r_valid <= 1'b1;
                r_data  <= d;
            end else if (pop) begin
                r_valid <= 1'b0;
            end
            if (pop && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_cnt   = r_cnt;

endmodule

// File: rtl/demux_1to4_reg.sv
// demux_1to4_reg
//   Registered 1-to-4 demultiplexer. One producer word per cycle is
//   steered by in_sel into one of four single-word output slots, each
//   drained by its own consumer with a valid/ready handshake.
//
//   Handshake rule (both sides): a word moves on a rising edge where
//   valid && ready. in_ready depends only on the selected slot
//   (empty, or being drained this cycle) and never on in_valid.
//
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : producer offers in_data for channel in_sel
//   in_ready   : selected slot can take a word this cycle
//   in_data    : producer word
//   in_sel     : destination channel 0..3 (a..d)
//   out_valid  : per-channel slot full, bit i = channel i
//   out_ready  : per-channel consumer ready
//   out_data   : channel i word at [i*WIDTH +: WIDTH]
//   xfer_cnt   : channel i handshake count at [i*CNT_W +: CNT_W]
module demux_1to4_reg
    import demux_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [SEL_W-1:0]        in_sel,
    output logic [NUM_CH-1:0]       out_valid,
    input  logic [NUM_CH-1:0]       out_ready,
    output logic [NUM_CH*WIDTH-1:0] out_data,
    output logic [NUM_CH*CNT_W-1:0] xfer_cnt
);

    logic [NUM_CH-1:0] w_sel_oh;
    logic [NUM_CH-1:0] w_load;
    logic [NUM_CH-1:0] w_pop;
    logic              w_accept;

    assign w_sel_oh = sel_decode(in_sel);

    // Selected slot accepts when empty or when it is emptied on this edge.
    assign in_ready = !out_valid[in_sel] || out_ready[in_sel];
    assign w_accept = in_valid && in_ready;
    assign w_load   = w_sel_oh & {NUM_CH{w_accept}};
    assign w_pop    = out_valid & out_ready;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
        demux_chan_slot #(
            .WIDTH (WIDTH),
            .CNT_W (CNT_W)
        ) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (w_load[g]),
            .pop     (w_pop[g]),
            .d       (in_data),
            .o_valid (out_valid[g]),
            .o_data  (out_data[g*WIDTH +: WIDTH]),
            .o_cnt   (xfer_cnt[g*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_demux_1to4_reg.sv
module tb_demux_1to4_reg;
    import demux_pkg::*;

    localparam int W    = 4;
    localparam int CW   = 8;
    localparam int CMAX = 255;

    // ---------------- clock / reset ----------------
    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [1:0]    in_sel;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic [4*W-1:0]  out_data;
    logic [4*CW-1:0] xfer_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    demux_1to4_reg #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .xfer_cnt  (xfer_cnt)
    );

    // ---------------- reference model / scoreboard ----------------
    // Per channel: words accepted and not yet delivered (front = slot content).
    logic [W-1:0] exp_q [4][$];
    logic [W-1:0] last_d [4];
    int           cnt_m [4];
    logic [3:0]   pend;      // word pushed this cycle, lands on the next edge
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            exp_q[i].delete();
            last_d[i] = '0;
            cnt_m[i]  = 0;
        end
        pend = '0;
    endtask

    // ---------------- driver ----------------
    // Called just after a rising edge; applies one cycle of stimulus.
    task automatic cyc(input logic v, input logic [1:0] s, input logic [W-1:0] d,
                       input logic [3:0] r);
        logic exp_rdy;
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
        #1;
        exp_rdy = (exp_q[s].size() == 0) || r[s];
        chk($sformatf("in_ready sel=%0d", s), 32'(in_ready), 32'(exp_rdy));
        if (v && exp_rdy) begin
            exp_q[s].push_back(d);
            pend[s] = 1'b1;
        end
        @(posedge clk);
        #1;
        pend = '0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        model_clear();
        #1;
        chk("reset out_valid", 32'(out_valid), 32'h0);
        chk("reset out_data",  32'(out_data),  32'h0);
        chk("reset xfer_cnt",  32'(xfer_cnt),  32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1;
            chk($sformatf("reset in_ready sel=%0d", s), 32'(in_ready), 32'h1);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            int         occ;
            logic [W-1:0] ed;
            occ = exp_q[i].size() - (pend[i] ? 1 : 0);
            ed  = (occ > 0) ? exp_q[i][0] : last_d[i];
            chk($sformatf("out_valid[%0d]", i), 32'(out_valid[i]), 32'(occ > 0));
            chk($sformatf("out_data[%0d]", i), 32'(out_data[i*W +: W]), 32'(ed));
            chk($sformatf("xfer_cnt[%0d]", i), 32'(xfer_cnt[i*CW +: CW]), 32'(cnt_m[i]));
            if (rst_n && occ > 0 && out_ready[i]) begin
                last_d[i] = exp_q[i].pop_front();
                if (cnt_m[i] < CMAX) cnt_m[i]++;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = '0;
        in_data   = '0;
        out_ready = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Single word to channel c, then drain it.
        cyc(1'b1, CH_C, 4'hA, 4'b0000);
        chk("first out_valid", 32'(out_valid), 32'b0100);
        cyc(1'b0, CH_A, 4'h0, 4'b0100);
        chk("first drained", 32'(out_valid), 32'h0);
        chk("first xfer_cnt[c]", 32'(xfer_cnt[2*CW +: CW]), 32'd1);

        // Back-pressure on channel a, then pop+reload on one edge.
        cyc(1'b1, CH_A, 4'h3, 4'b0000);
        repeat (5) cyc(1'b1, CH_A, 4'h7, 4'b0000);
        chk("bp hold data", 32'(out_data[W-1:0]), 32'h3);
        cyc(1'b1, CH_A, 4'h7, 4'b0001);
        chk("bp reload valid", 32'(out_valid[0]), 32'h1);
        chk("bp reload data", 32'(out_data[W-1:0]), 32'h7);
        cyc(1'b0, CH_A, 4'h0, 4'b1111);

        // Independence: b stalled full, d still accepts.
        cyc(1'b1, CH_B, 4'h9, 4'b0000);
        cyc(1'b1, CH_D, 4'h5, 4'b0000);
        chk("indep out_valid", 32'(out_valid), 32'b1010);
        cyc(1'b0, CH_A, 4'h0, 4'b1111);

        // Streaming 1..8 into channel b.
        do_reset();
        for (int k = 1; k <= 8; k++) cyc(1'b1, CH_B, 4'(k), 4'b1111);
        cyc(1'b0, CH_A, 4'h0, 4'b1111);
        chk("stream xfer_cnt[b]", 32'(xfer_cnt[CW +: CW]), 32'd8);

        // Saturation on channel a.
        for (int k = 0; k < 300; k++) cyc(1'b1, CH_A, 4'($urandom_range(0, 15)), 4'b0001);
        cyc(1'b0, CH_A, 4'h0, 4'b0001);
        chk("sat xfer_cnt[a]", 32'(xfer_cnt[CW-1:0]), 32'd255);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        // Mid-operation reset with all slots full.
        for (int s = 0; s < 4; s++) cyc(1'b1, 2'(s), 4'(s + 1), 4'b0000);
        chk("pre-reset all full", 32'(out_valid), 32'hF);
        do_reset();
        cyc(1'b1, CH_C, 4'hA, 4'b0000);
        chk("post-reset out_valid", 32'(out_valid), 32'b0100);
        cyc(1'b0, CH_A, 4'h0, 4'b0100);
        chk("post-reset xfer_cnt[c]", 32'(xfer_cnt[2*CW +: CW]), 32'd1);
        cyc(1'b0, CH_A, 4'h0, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
